// File: rtl/button_monitor.sv
// button_monitor: per-bit two-flop synchroniser, debounce filter and one-cycle press pulse.
// Define BUTTON_MONITOR_RELEASE_EN to add the debounced release pulse output buttonRelease.
module button_monitor #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttonPress,
    output logic [WIDTH-1:0] buttonEdge
`ifdef BUTTON_MONITOR_RELEASE_EN
    ,
    output logic [WIDTH-1:0] buttonRelease
`endif
);

    localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttonPress;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic          db;
        logic [CW-1:0] cnt;
        logic          accept;
        logic          edge_q;

        // Accept once the synchronised level has differed for DEBOUNCE_CYCLES edges in a row.
        assign accept = (sync2[g] != db) && (cnt == CMAX);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                db     <= 1'b0;
                cnt    <= '0;
                edge_q <= 1'b0;
            end else begin
                edge_q <= accept & sync2[g];
                if (accept) begin
                    db  <= sync2[g];
                    cnt <= '0;
                end else if (sync2[g] == db) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign buttonEdge[g] = edge_q;

`ifdef BUTTON_MONITOR_RELEASE_EN
        logic rel_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rel_q <= 1'b0;
            end else begin
                rel_q <= accept & ~sync2[g];
            end
        end

        assign buttonRelease[g] = rel_q;
`endif
    end

endmodule

// File: tb/tb_button_monitor.sv
// Self-checking bench for button_monitor: directed press/bounce/reset scenarios plus random
// stimulus compared every cycle against a run-length debounce model.
module tb_button_monitor;

    localparam int W = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] buttonPress = '0;
    logic [W-1:0] buttonEdge;
    logic [W-1:0] rel_obs;

`ifdef BUTTON_MONITOR_RELEASE_EN
    logic [W-1:0] buttonRelease;
    assign rel_obs = buttonRelease;
    button_monitor #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .buttonPress(buttonPress),
        .buttonEdge(buttonEdge), .buttonRelease(buttonRelease));
`else
    assign rel_obs = '0;
    button_monitor #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .buttonPress(buttonPress),
        .buttonEdge(buttonEdge));
`endif

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: the level seen by the filter is the input sampled two edges earlier; a level is
    // accepted after it has differed from the debounced level for D consecutive edges.
    logic [W-1:0] hist1 = '0, hist2 = '0, mdb = '0;
    int           run [W];
    logic [W-1:0] exp_edge = '0, exp_rel = '0;

    always @(posedge clock) begin
        if (reset) begin
            hist1 = '0; hist2 = '0; mdb = '0;
            exp_edge = '0; exp_rel = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                exp_edge[i] = 1'b0;
                exp_rel[i]  = 1'b0;
                if (hist2[i] != mdb[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == D) begin
                        mdb[i]      = hist2[i];
                        exp_edge[i] = hist2[i];
                        exp_rel[i]  = ~hist2[i];
                        run[i]      = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            hist2 = hist1;
            hist1 = buttonPress;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            checks++;
            if (buttonEdge !== exp_edge) begin
                errors++;
                $display("FAIL edge_model t=%0t got %b want %b", $time, buttonEdge, exp_edge);
            end
`ifdef BUTTON_MONITOR_RELEASE_EN
            checks++;
            if (buttonRelease !== exp_rel) begin
                errors++;
                $display("FAIL release_model t=%0t got %b want %b", $time, buttonRelease, exp_rel);
            end
            checks++;
            if ((buttonRelease & buttonEdge) !== '0) begin
                errors++;
                $display("FAIL edge_release_overlap t=%0t edge %b release %b", $time, buttonEdge, buttonRelease);
            end
`endif
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // Drive pat for n cycles; report the first cycle (1-based, counted from the first sampling
    // edge) with a press pulse, its value, the pulse count, and the same for release pulses.
    task automatic run_pattern(input logic [W-1:0] pat, input int n,
                               output int first, output logic [W-1:0] val, output int npulse,
                               output int rfirst, output int rnpulse);
        first = 0; val = '0; npulse = 0; rfirst = 0; rnpulse = 0;
        buttonPress = pat;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (buttonEdge != '0) begin
                if (first == 0) begin
                    first = k;
                    val   = buttonEdge;
                end
                npulse++;
            end
            if (rel_obs != '0) begin
                if (rfirst == 0) rfirst = k;
                rnpulse++;
            end
        end
    endtask

    int           f, np, rf, rnp, np2;
    logic [W-1:0] v;

    initial begin
        for (int i = 0; i < W; i++) run[i] = 0;
        repeat (3) @(negedge clock);
        started = 1'b1;
        check_vec("reset_edge", buttonEdge, '0);
        reset = 1'b0;

        run_pattern(4'b0000, 20, f, v, np, rf, rnp);
        check_int("idle_pulses", np, 0);

        run_pattern(4'b0001, 20, f, v, np, rf, rnp);
        check_int("press0_latency", f, 6);
        check_vec("press0_value", v, 4'b0001);
        check_int("press0_count", np, 1);
        run_pattern(4'b0000, 10, f, v, np, rf, rnp);
        check_int("release0_no_edge", np, 0);
`ifdef BUTTON_MONITOR_RELEASE_EN
        check_int("release0_latency", rf, 6);
        check_int("release0_count", rnp, 1);
`endif

        run_pattern(4'b0100, 3, f, v, np, rf, rnp);
        run_pattern(4'b0000, 20, f, v, np2, rf, rnp);
        check_int("bounce_pulses", np + np2, 0);

        run_pattern(4'b1010, 20, f, v, np, rf, rnp);
        check_int("dual_latency", f, 6);
        check_vec("dual_value", v, 4'b1010);
        check_int("dual_count", np, 1);
        run_pattern(4'b0000, 10, f, v, np, rf, rnp);
        run_pattern(4'b1000, 20, f, v, np, rf, rnp);
        check_int("repress3_latency", f, 6);
        check_vec("repress3_value", v, 4'b1000);
        check_int("repress3_count", np, 1);
        run_pattern(4'b0000, 10, f, v, np, rf, rnp);

        // Reset lands on edge 4 of a debounce; the held press must be re-reported afterwards.
        run_pattern(4'b0100, 3, f, v, np, rf, rnp);
        check_int("prereset_pulses", np, 0);
        reset = 1'b1;
        #1;
        check_vec("async_reset_edge", buttonEdge, '0);
        repeat (2) @(negedge clock);
        check_vec("in_reset_edge", buttonEdge, '0);
        reset = 1'b0;
        run_pattern(4'b0100, 20, f, v, np, rf, rnp);
        check_int("postreset_latency", f, 6);
        check_vec("postreset_value", v, 4'b0100);
        check_int("postreset_count", np, 1);
        run_pattern(4'b0000, 10, f, v, np, rf, rnp);

        // Random phase: sparse toggles give both bounces and long holds; occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) buttonPress[i] = ~buttonPress[i];
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            else reset = 1'b0;
            @(negedge clock);
        end
        reset = 1'b0;
        buttonPress = '0;
        repeat (10) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
